alu_cmd_sequencer: RTL and testbench

Command-side front end for the team's 32-bit registered ALU (`alu32`). It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. It issues each request to the ALU, holding the operands stable for the ALU's pipeline latency, and captures `out`/`overflow`. Each result is returned over a valid/ready response channel. It sits between a command source (CPU model or testbench driver) and one `alu32` instance.

---
 rtl/alu_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture sequencer in front of a registered 32-bit ALU.
// Optional ALU_SEQ_ILLEGAL_CHECK_EN: opcodes above SUB skip the ALU and return rsp_err.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [3:0]  cmd_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_overflow,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [31:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [31:0]   data_q, data_d;
    logic          ovf_q, ovf_d;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= cmd_t'{cmd_a, cmd_b, cmd_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
    logic err_q, err_d;
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
                    if (head.sel > 4'd4) begin
                        data_d  = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else
`endif
                    begin
                        alu_a_d   = head.a;
                        alu_b_d   = head.b;
                        alu_sel_d = head.sel;
                        lat_d     = '0;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // operands have been stable ALU_LAT edges; result is valid now
                if (lat_q == CW'(ALU_LAT - 1)) begin
                    data_d  = alu_out;
                    ovf_d   = alu_overflow;
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = data_q;
    assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a one-register ALU model.
// Expected illegal-opcode behaviour follows ALU_SEQ_ILLEGAL_CHECK_EN.
module tb_alu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 2;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_sel;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_overflow, rsp_err;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        err;
        int          acc;
        int          lat;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   n_rise = 0;
    int   last_rise = 0;
    logic prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: operands applied at one edge, result registered at the next
    function automatic logic [32:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [3:0] s);
        case (s)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {1'b0, a ^ b};
            4'd3:    return {1'b0, a} + {1'b0, b};
            4'd4:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
            default: return 33'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        {alu_overflow, alu_out} <= alu_f(alu_a, alu_b, alu_sel);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v) begin
                n_rise++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 want 0");
                end else begin
                    if (exp_q[0].lat >= 0)
                        check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                    if (exp_q[0].gap >= 0)
                        check("spacing", cyc - last_rise, exp_q[0].gap);
                end
                last_rise = cyc;
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                check("rsp_data", rsp_data, exp_q[0].data);
                check("rsp_overflow", 32'(rsp_overflow), 32'(exp_q[0].ovf));
                check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end
            prev_v = rsp_valid;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [31:0] ed,
                        input logic eo, input logic ee, input int lat,
                        input int gap, input int budget, output bit acc);
        exp_t e;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e.data = ed; e.ovf = eo; e.err = ee;
                e.acc = cyc; e.lat = lat; e.gap = gap;
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic [31:0] ed,
                           input logic eo, input int lat, input int gap);
        bit acc;
        send(a, b, sel, ed, eo, 1'b0, lat, gap, 40, acc);
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout: got cmd_ready=0 want 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    logic [31:0] bp_a   [5] = '{32'h10, 32'h3, 32'h100, 32'h20, 32'hFF};
    logic [31:0] bp_b   [5] = '{32'h01, 32'h5, 32'h200, 32'h08, 32'h0F};
    logic [3:0]  bp_s   [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [31:0] bp_d   [5] = '{32'h11, 32'h6, 32'h300, 32'h18, 32'h0F};
    logic        bp_o   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int  n_acc;
        int  rise0;
        bit  acc, seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_sel = '0; rsp_ready = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send_ok(32'hF0F0F0F0, 32'hFF00FF00, 4'd0, 32'hF000F000, 1'b0, 4, -1);
        drain();
        send_ok(32'hFFFFFFFF, 32'h1, 4'd3, 32'h0, 1'b1, 4, -1);
        drain();
        send_ok(32'd7, 32'd5, 4'd4, 32'h2, 1'b1, 4, -1);
        send_ok(32'd5, 32'd7, 4'd4, 32'hFFFFFFFE, 1'b0, -1, ALU_LAT + 2);
        drain();

`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
        send(32'h1234, 32'h5678, 4'b1001, 32'h0, 1'b0, 1'b1, -1, -1, 40, acc);
        drain();
        check("ill_alu_sel", 32'(alu_sel), 4);
        check("ill_alu_a", alu_a, 5);
`else
        send(32'h1234, 32'h5678, 4'b1001, 32'h0, 1'b0, 1'b0, 4, -1, 40, acc);
        drain();
        check("ill_alu_sel", 32'(alu_sel), 9);
        check("ill_alu_a", alu_a, 32'h1234);
`endif

        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(i < 5 ? bp_a[i % 5] : 32'hA0 + i, i < 5 ? bp_b[i % 5] : 32'h1,
                 i < 5 ? bp_s[i % 5] : 4'd3, i < 5 ? bp_d[i % 5] : 32'h0,
                 i < 5 ? bp_o[i % 5] : 1'b0, 1'b0,
                 i == 0 ? 4 : -1, (i >= 2) ? ALU_LAT + 2 : -1, 12, acc);
            if (!acc) break;
            n_acc++;
        end
        check("bp_accepted", n_acc, 5);
        check("bp_cmd_ready", 32'(cmd_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cmd_ready;
        end
        check("bp_ready_back", 32'(seen), 1);
        drain();

        send_ok(32'h1, 32'h2, 4'd3, 32'h3, 1'b0, 4, -1);
        send_ok(32'h4, 32'h2, 4'd4, 32'h2, 1'b1, -1, -1);
        send_ok(32'h9, 32'h3, 4'd1, 32'hB, 1'b0, -1, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        check("mid_rst_alu_sel", 32'(alu_sel), 0);
        check("mid_rst_alu_a", alu_a, 0);
        rise0 = n_rise;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_rsp", n_rise, rise0);
        send_ok(32'h12345678, 32'h11111111, 4'd3, 32'h23456789, 1'b0, 4, -1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
